// File: rtl/aik_pkg.sv
// Shared Aiken (2421) code definitions: FSM states, illegal-code bounds and the digit decoder.
package aik_pkg;

    typedef enum logic {
        StAcc,
        StDone
    } aik_state_e;

    localparam logic [3:0] AIK_ILL_LO = 4'b0101;
    localparam logic [3:0] AIK_ILL_HI = 4'b1010;
    localparam logic [3:0] AIK_OFFSET = 4'd6;

    // Returns {illegal, digit}; illegal codes decode to digit 0.
    function automatic logic [4:0] aik_decode(input logic [3:0] code);
        logic [4:0] res;
        if (code < AIK_ILL_LO) begin
            res = {1'b0, code};
        end else if (code > AIK_ILL_HI) begin
            res = {1'b0, code - AIK_OFFSET};
        end else begin
            res = {1'b1, 4'd0};
        end
        return res;
    endfunction

endpackage

// File: rtl/aik_digit_dec.sv
// Combinational single-digit Aiken (2421) decoder, shared by Aiken receive paths.
module aik_digit_dec
    import aik_pkg::*;
(
    input  logic [3:0] code,
    output logic [3:0] digit,
    output logic       illegal
);

    always_comb begin
        {illegal, digit} = aik_decode(code);
    end

endmodule

// File: rtl/aik2bin_acc.sv
// Serial Aiken (2421) to binary accumulator, MSD first, valid/ready in and out.
// Optional length check enabled by defining AIK2BIN_LEN_CHECK_EN.
module aik2bin_acc
    import aik_pkg::*;
#(
    parameter int unsigned DIGITS = 4,
    localparam int unsigned OUT_W = $clog2(10 ** DIGITS),
    localparam int unsigned CNT_W = $clog2(DIGITS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       in_aiken,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [OUT_W-1:0] out_bin,
    output logic             out_err,
    output logic [CNT_W-1:0] out_ndig,
    output logic             out_valid,
    input  logic             out_ready
);

    aik_state_e       state;
    logic [OUT_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             err;

    logic [3:0]       digit;
    logic             illegal;
    logic [OUT_W-1:0] acc_x10;
    logic [OUT_W-1:0] acc_mac;
    logic [CNT_W-1:0] cnt_inc;
    logic             cnt_full;
    logic             accept;

    aik_digit_dec u_dec (
        .code    (in_aiken),
        .digit   (digit),
        .illegal (illegal)
    );

    always_comb begin
        acc_x10  = (acc << 3) + (acc << 1);
        acc_mac  = acc_x10 + OUT_W'(digit);
        cnt_full = (cnt == CNT_W'(DIGITS));
        cnt_inc  = cnt_full ? cnt : cnt + CNT_W'(1);
        accept   = in_valid && (state == StAcc);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= StAcc;
            acc   <= '0;
            cnt   <= '0;
            err   <= 1'b0;
        end else begin
            unique case (state)
                StAcc: begin
                    if (accept) begin
                        cnt <= cnt_inc;
`ifdef AIK2BIN_LEN_CHECK_EN
                        // Over-length digits poison the frame but never disturb acc.
                        if (cnt_full) begin
                            err <= 1'b1;
                        end else begin
                            acc <= acc_mac;
                            err <= err | illegal;
                        end
`else
                        acc <= acc_mac;
                        err <= err | illegal;
`endif
                        if (in_last) begin
                            state <= StDone;
                        end
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        state <= StAcc;
                        acc   <= '0;
                        cnt   <= '0;
                        err   <= 1'b0;
                    end
                end
                default: state <= StAcc;
            endcase
        end
    end

    // Handshake flags come from the state register only: no input-to-output paths.
    assign in_ready  = (state == StAcc);
    assign out_valid = (state == StDone);
    assign out_bin   = acc;
    assign out_err   = err;
    assign out_ndig  = cnt;

endmodule

// File: tb/tb_aik2bin_acc.sv
// Scoreboard bench for aik2bin_acc: directed Aiken frames, queue-based result checking.
module tb_aik2bin_acc;

    localparam int unsigned DIGITS = 4;
    localparam int unsigned OUT_W  = 14;
    localparam int unsigned CNT_W  = 3;

    typedef struct {
        int bin;
        int err;
        int ndig;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic [3:0]       in_aiken;
    logic             in_valid;
    logic             in_last;
    logic             in_ready;
    logic [OUT_W-1:0] out_bin;
    logic             out_err;
    logic [CNT_W-1:0] out_ndig;
    logic             out_valid;
    logic             out_ready;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    aik2bin_acc #(.DIGITS(DIGITS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_aiken  (in_aiken),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_bin   (out_bin),
        .out_err   (out_err),
        .out_ndig  (out_ndig),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push_exp(input int bin, input int err, input int ndig);
        exp_t e;
        e.bin  = bin;
        e.err  = err;
        e.ndig = ndig;
        exp_q.push_back(e);
    endtask

    // Drive one digit and return #1 after the edge on which it was accepted.
    task automatic send_digit(input logic [3:0] code, input logic last);
        int  n    = 0;
        bit  done = 0;
        in_valid = 1'b1;
        in_aiken = code;
        in_last  = last;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                done = 1;
            end else if (++n > 50) begin
                check("accept_timeout", 0, 1);
                done = 1;
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare one scoreboard entry per output handshake.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("out_bin", int'(out_bin), e.bin);
                check("out_err", int'(out_err), e.err);
                check("out_ndig", int'(out_ndig), e.ndig);
            end
        end
    end

    initial begin
        logic [OUT_W-1:0] hold_bin;
        logic             hold_err;
        logic [CNT_W-1:0] hold_ndig;
        int               n;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_aiken  = 4'd0;
        out_ready = 1'b1;
        repeat (2) tick();
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_bin", int'(out_bin), 0);
        rst_n = 1'b1;
        tick();
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_err", int'(out_err), 0);
        check("rst_out_ndig", int'(out_ndig), 0);

        // 5,2,9 with a stall and a stray in_last between digits
        push_exp(529, 0, 3);
        send_digit(4'b1011, 1'b0);
        in_last = 1'b1;
        tick();
        in_last = 1'b0;
        tick();
        check("stray_last_ignored", int'(in_ready), 1);
        send_digit(4'b0010, 1'b0);
        send_digit(4'b1111, 1'b1);
        check("latency_out_valid", int'(out_valid), 1);
        check("done_in_ready", int'(in_ready), 0);
        tick();

        // illegal 0111 decodes to 0 and flags error
        push_exp(10, 1, 2);
        send_digit(4'b0001, 1'b0);
        send_digit(4'b0111, 1'b1);
        tick();

        // one-digit frames back to back, out_ready high
        push_exp(0, 0, 1);
        push_exp(9, 0, 1);
        send_digit(4'b0000, 1'b1);
        check("single0_in_ready_low", int'(in_ready), 0);
        tick();
        check("single0_in_ready_back", int'(in_ready), 1);
        send_digit(4'b1111, 1'b1);
        check("single9_in_ready_low", int'(in_ready), 0);
        tick();
        check("single9_in_ready_back", int'(in_ready), 1);

        // backpressure with a pending digit held on the input
        push_exp(3, 0, 1);
        out_ready = 1'b0;
        send_digit(4'b0011, 1'b1);
        hold_bin  = out_bin;
        hold_err  = out_err;
        hold_ndig = out_ndig;
        in_valid  = 1'b1;
        in_aiken  = 4'b0100;
        in_last   = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_in_ready", int'(in_ready), 0);
            check("bp_out_valid", int'(out_valid), 1);
            check("bp_out_bin", int'(out_bin), int'(hold_bin));
            check("bp_out_err", int'(out_err), int'(hold_err));
            check("bp_out_ndig", int'(out_ndig), int'(hold_ndig));
        end
        check("bp_held_value", int'(out_bin), 3);
        push_exp(4, 0, 1);
        out_ready = 1'b1;
        send_digit(4'b0100, 1'b1);
        tick();

        // over-length frame: 1,2,3,4,5
`ifdef AIK2BIN_LEN_CHECK_EN
        push_exp(1234, 1, 4);
`else
        push_exp(12345, 0, 4);
`endif
        send_digit(4'b0001, 1'b0);
        send_digit(4'b0010, 1'b0);
        send_digit(4'b0011, 1'b0);
        send_digit(4'b0100, 1'b0);
        send_digit(4'b1011, 1'b1);
        tick();

        // reset mid-frame discards the partial frame
        send_digit(4'b0001, 1'b0);
        send_digit(4'b0010, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_out_bin", int'(out_bin), 0);
        check("midrst_out_err", int'(out_err), 0);
        check("midrst_out_ndig", int'(out_ndig), 0);
        tick();
        rst_n = 1'b1;
        tick();
        check("postrst_in_ready", int'(in_ready), 1);
        check("postrst_out_valid", int'(out_valid), 0);
        push_exp(6, 0, 1);
        send_digit(4'b1100, 1'b1);
        tick();

        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            tick();
            n++;
        end
        check("scoreboard_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/aik2bin_acc.md
# aik2bin_acc

Serial Aiken (2421) to binary accumulator. Accepts a frame of Aiken-coded decimal digits, most significant digit first, over a valid/ready stream. Converts the frame to one unsigned binary value, flags illegal codes, and presents the result on a valid/ready output. It is the receive-side counterpart of the binary-to-Aiken encoder and sits after any Aiken digit source, such as a keypad front end or a serial link.

## Interface
- DIGITS, default 4: maximum digits per frame. Derived `OUT_W = $clog2(10**DIGITS)`, which is 14 at the default; `CNT_W = $clog2(DIGITS+1)`.
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous and active-low.
- in_aiken  input  4  Aiken digit code.
- in_valid  input  1  digit present.
- in_last  input  1  qualifies the final digit of a frame.
- in_ready  output  1  block can accept a digit.
- out_bin  output  OUT_W  binary value of the frame.
- out_err  output  1  at least one illegal code in the frame, or a length violation (see Configuration).
- out_ndig  output  CNT_W  digits accepted, saturating at DIGITS.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts the result.

## Operation
- Digit decode:
  - codes 0000–0100 decode to 0–4.
  - codes 1011–1111 decode to 5–9 (value = code − 6).
  - codes 0101–1010 are illegal. They decode to 0 and set the error flag.
- State machine with two states, ACC and DONE. The state, `acc[OUT_W-1:0]`, `cnt` and `err` are all registered.
- Behaviour in ACC:
  - in_ready = 1 and out_valid = 0.
  - On `in_valid & in_ready`: `acc <= acc*10 + d`, truncated mod 2^OUT_W. `cnt <= min(cnt+1, DIGITS)`. `err <= err | illegal`.
  - If in_last is also high, go to DONE.
- Behaviour in DONE:
  - in_ready = 0 and out_valid = 1.
  - out_bin = acc, out_err = err, out_ndig = cnt, all held stable.
  - On out_ready, go to ACC and clear acc, cnt and err to 0 in the same edge.
- in_last without in_valid is ignored.
- A one-digit frame is legal.
- Zero-digit frames cannot occur.
- Reset values:
  - state = ACC.
  - acc = 0, cnt = 0, err = 0.
  - in_ready = 1 once rst_n deasserts.
  - out_valid = 0, out_bin = 0, out_err = 0, out_ndig = 0.
- Reset asserted mid-frame discards the partial frame immediately, with no output.

## Timing
- in_ready and out_valid are decoded from the state register only. There is no combinational path from in_valid or out_ready.
- Latency: the last digit is accepted at edge N. out_valid is high from the cycle after edge N.
- Throughput: a frame of k digits occupies k+1 cycles minimum (k accepts plus one DONE cycle with out_ready = 1).
- A digit cannot be accepted in the same cycle that a result is consumed. The next frame's first digit is accepted no earlier than the cycle after the out_ready handshake.
- Backpressure: while out_ready = 0, DONE holds indefinitely, in_ready stays 0, and all outputs stay stable.
- Stall tolerance: in_valid may drop between digits of a frame. The accumulator holds its value.

## Configuration
- Macro: `AIK2BIN_LEN_CHECK_EN`.
- Defined: a digit accepted while `cnt == DIGITS` sets err and leaves acc unchanged. This applies to any digit, including a last digit.
- Undefined:
  - Excess digits still accumulate mod 2^OUT_W.
  - Length never affects err.
  - cnt still saturates at DIGITS.

## Structure
- Package `aik_pkg` holds:
  - the state enum (ACC, DONE).
  - localparams for the illegal-code range bounds (4'b0101, 4'b1010) and the offset 6.
  - the function `aik_decode(code) -> {illegal, digit[3:0]}`.
- Sub-module `aik_digit_dec` is a combinational wrapper around `aik_decode`. It is instantiated once and is reused by future Aiken receivers.
- The multiply-by-10 is implemented as `(acc<<3)+(acc<<1)`.

## Test plan
- Frame 1011, 0010, 1111 (last): out_bin = 529, out_err = 0, out_ndig = 3, out_valid one cycle after the last accept.
- Frame 0001, 0111 (last), where 0111 is illegal: out_bin = 10, out_err = 1, out_ndig = 2.
- Single digit 0000 with last, then single digit 1111 with last, both with out_ready tied high: results 0 then 9. in_ready is low for exactly one cycle per frame.
- Backpressure: hold out_ready = 0 for 5 cycles in DONE while driving in_valid = 1. in_ready stays 0, outputs stay stable, and no digit is lost. The next frame, 0100 (last), yields 4.
- DIGITS = 4, frame 0001, 0010, 0011, 0100, 1011 (last):
  - with `AIK2BIN_LEN_CHECK_EN` defined: out_bin = 1234, out_err = 1, out_ndig = 4.
  - without the macro: out_bin = 12345, out_err = 0, out_ndig = 4.
- Assert rst_n low after 2 of 3 digits. All outputs are 0 and in_ready = 1 after release. A following frame, 1100 (last), yields 6 with out_ndig = 1.
